mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, data port and shared memory port of the arbiter.
// The arbiter uses the slave view; the CPU/memory side uses the master view.
interface mem_arbiter_if #(
    parameter int WORD_SIZE = 16
);
    logic                 i_req;
    logic [WORD_SIZE-1:0] i_addr;
    logic [WORD_SIZE-1:0] i_rdata;
    logic                 i_done;

    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic [WORD_SIZE-1:0] d_rdata;
    logic                 d_done;

    logic                 mem_req;
    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic                 mem_ack;

    logic                 busy;
    logic                 timeout_err;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_rdata, i_done, d_rdata, d_done,
        input  mem_req, mem_we, mem_addr, mem_wdata, busy, timeout_err
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_rdata, i_done, d_rdata, d_done,
        output mem_req, mem_we, mem_addr, mem_wdata, busy, timeout_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share a
// single memory port. Data wins ties unless fetch has lost STARVE_LIMIT ties
// in a row. A service that sees no mem_ack for TIMEOUT cycles is aborted,
// completed with a done pulse, and flagged in the sticky timeout_err.
module mem_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input logic           clk,
    input logic           reset,
    mem_arbiter_if.slave  bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERV_I = 2'd1,
        SERV_D = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;

    logic [SW-1:0]        starve_cnt;
    logic [WW-1:0]        wait_cnt;

    logic [WORD_SIZE-1:0] lat_addr;
    logic                 lat_we;
    logic [WORD_SIZE-1:0] lat_wdata;

    logic [WORD_SIZE-1:0] i_rdata_q;
    logic [WORD_SIZE-1:0] d_rdata_q;
    logic                 i_done_q;
    logic                 d_done_q;
    logic                 timeout_q;

    logic                 eff_i;
    logic                 eff_d;
    logic                 enter_i;
    logic                 enter_d;
    logic                 tie_to_d;
    logic                 complete;
    logic                 abort;
    logic                 serving;

    assign serving = (state != IDLE);

    // A request is ignored in the cycle its own done pulse is high, so a
    // held request is not granted a second time by accident.
    assign eff_i = bus.i_req & ~i_done_q;
    assign eff_d = bus.d_req & ~d_done_q;

    // Arbitration in IDLE and completion/abort detection during service.
    always_comb begin
        next_state = state;
        enter_i    = 1'b0;
        enter_d    = 1'b0;
        tie_to_d   = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (eff_i && eff_d) begin
                    if (starve_cnt >= STARVE_MAX) begin
                        enter_i = 1'b1;
                    end else begin
                        enter_d  = 1'b1;
                        tie_to_d = 1'b1;
                    end
                end else if (eff_d) begin
                    enter_d = 1'b1;
                end else if (eff_i) begin
                    enter_i = 1'b1;
                end
                if (enter_i) begin
                    next_state = SERV_I;
                end else if (enter_d) begin
                    next_state = SERV_D;
                end
            end
            SERV_I, SERV_D: begin
                if (bus.mem_ack) begin
                    complete   = 1'b1;
                    next_state = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Fairness counter: counts ties lost by fetch, cleared whenever fetch is served.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (enter_i) begin
            starve_cnt <= '0;
        end else if (tie_to_d && (starve_cnt < STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Watchdog: counts service cycles that went by without an acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (enter_i || enter_d) begin
            wait_cnt <= '0;
        end else if (serving && !complete && !abort) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Capture the winning port's request so the memory side stays stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
        end else if (enter_i) begin
            lat_addr  <= bus.i_addr;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
        end else if (enter_d) begin
            lat_addr  <= bus.d_addr;
            lat_we    <= bus.d_we;
            lat_wdata <= bus.d_wdata;
        end
    end

    // Completion pulses, read data capture and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            i_done_q <= (complete || abort) && (state == SERV_I);
            d_done_q <= (complete || abort) && (state == SERV_D);
            if (complete && (state == SERV_I)) begin
                i_rdata_q <= bus.mem_rdata;
            end
            if (complete && (state == SERV_D) && !lat_we) begin
                d_rdata_q <= bus.mem_rdata;
            end
            if (abort) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.mem_req     = serving;
    assign bus.mem_we      = (state == SERV_D) & lat_we;
    assign bus.mem_addr    = serving ? lat_addr : '0;
    assign bus.mem_wdata   = (state == SERV_D) ? lat_wdata : '0;
    assign bus.busy        = serving;
    assign bus.timeout_err = timeout_q;
    assign bus.i_done      = i_done_q;
    assign bus.d_done      = d_done_q;
    assign bus.i_rdata     = i_rdata_q;
    assign bus.d_rdata     = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int WS    = 16;
    localparam int SLIM  = 4;
    localparam int TOUT  = 8;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    // Reference model: which port is being served (0 none, 1 fetch, 2 data),
    // how many ties fetch has lost, and how long the current service waited.
    int              m_serving;
    int              m_starve;
    int              m_waited;
    logic [WS-1:0]   m_addr;
    logic            m_we;
    logic [WS-1:0]   m_wdata;
    logic [WS-1:0]   m_irdata;
    logic [WS-1:0]   m_drdata;
    logic            m_idone;
    logic            m_ddone;
    logic            m_terr;

    mem_arbiter_if #(.WORD_SIZE(WS)) bus ();

    mem_arbiter #(
        .WORD_SIZE    (WS),
        .STARVE_LIMIT (SLIM),
        .TIMEOUT      (TOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic ir, input logic [WS-1:0] ia,
                                  input logic dr, input logic dw,
                                  input logic [WS-1:0] da, input logic [WS-1:0] dd,
                                  input logic ack, input logic [WS-1:0] rd);
        bus.i_req     = ir;
        bus.i_addr    = ia;
        bus.d_req     = dr;
        bus.d_we      = dw;
        bus.d_addr    = da;
        bus.d_wdata   = dd;
        bus.mem_ack   = ack;
        bus.mem_rdata = rd;
    endtask

    task automatic model_edge();
        bit want_i;
        bit want_d;
        int grant;
        if (reset) begin
            m_serving = 0; m_starve = 0; m_waited = 0;
            m_addr = '0; m_we = 1'b0; m_wdata = '0;
            m_irdata = '0; m_drdata = '0;
            m_idone = 1'b0; m_ddone = 1'b0; m_terr = 1'b0;
            return;
        end
        want_i  = bus.i_req && !m_idone;
        want_d  = bus.d_req && !m_ddone;
        m_idone = 1'b0;
        m_ddone = 1'b0;
        if (m_serving == 0) begin
            grant = 0;
            if (want_i && want_d) begin
                if (m_starve >= SLIM) begin
                    grant = 1;
                end else begin
                    grant = 2;
                    m_starve = (m_starve + 1 > SLIM) ? SLIM : m_starve + 1;
                end
            end else if (want_d) begin
                grant = 2;
            end else if (want_i) begin
                grant = 1;
            end
            if (grant == 1) begin
                m_starve = 0;
                m_addr   = bus.i_addr;
                m_we     = 1'b0;
                m_wdata  = '0;
            end else if (grant == 2) begin
                m_addr   = bus.d_addr;
                m_we     = bus.d_we;
                m_wdata  = bus.d_wdata;
            end
            m_serving = grant;
            m_waited  = 0;
        end else if (bus.mem_ack) begin
            if (m_serving == 1) begin
                m_idone  = 1'b1;
                m_irdata = bus.mem_rdata;
            end else begin
                m_ddone = 1'b1;
                if (!m_we) m_drdata = bus.mem_rdata;
            end
            m_serving = 0;
        end else begin
            m_waited++;
            if (m_waited == TOUT) begin
                if (m_serving == 1) m_idone = 1'b1;
                else                m_ddone = 1'b1;
                m_terr    = 1'b1;
                m_serving = 0;
            end
        end
    endtask

    task automatic check_output();
        check("mem_req",     32'(bus.mem_req),     32'(m_serving != 0));
        check("busy",        32'(bus.busy),        32'(m_serving != 0));
        check("mem_we",      32'(bus.mem_we),      32'((m_serving == 2) && m_we));
        check("mem_addr",    32'(bus.mem_addr),    32'((m_serving != 0) ? m_addr : '0));
        check("mem_wdata",   32'(bus.mem_wdata),   32'((m_serving == 2) ? m_wdata : '0));
        check("i_done",      32'(bus.i_done),      32'(m_idone));
        check("d_done",      32'(bus.d_done),      32'(m_ddone));
        check("i_rdata",     32'(bus.i_rdata),     32'(m_irdata));
        check("d_rdata",     32'(bus.d_rdata),     32'(m_drdata));
        check("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
        check("done_excl",   32'(bus.i_done & bus.d_done), 32'd0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_output();
    endtask

    // Directed scenarios, then randomized traffic against the model.
    initial begin
        $display("[TB] mem_arbiter bench start");
        reset = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_req",  32'(bus.mem_req), 32'd0);
        reset = 1'b0;

        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 16'hDEAD);
        cycle();
        check("ack_in_idle", 32'(bus.busy), 32'd0);

        apply_stimulus(1, 16'h0010, 0, 0, 0, 0, 0, 0);
        cycle();
        check("fetch_addr", 32'(bus.mem_addr), 32'h0010);
        check("fetch_we",   32'(bus.mem_we), 32'd0);
        apply_stimulus(1, 16'h0010, 0, 0, 0, 0, 1, 16'hA5A5);
        cycle();
        check("fetch_done",  32'(bus.i_done), 32'd1);
        check("fetch_rdata", 32'(bus.i_rdata), 32'hA5A5);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        apply_stimulus(1, 16'h0020, 1, 0, 16'h0200, 0, 0, 0);
        cycle();
        check("tie_data_first", 32'(bus.mem_addr), 32'h0200);
        apply_stimulus(1, 16'h0020, 1, 0, 16'h0200, 0, 1, 16'hBEEF);
        cycle();
        check("tie_d_done", 32'(bus.d_done), 32'd1);
        check("tie_d_rdata", 32'(bus.d_rdata), 32'hBEEF);
        apply_stimulus(1, 16'h0020, 0, 0, 0, 0, 0, 0);
        cycle();
        check("tie_fetch_next", 32'(bus.mem_addr), 32'h0020);
        apply_stimulus(1, 16'h0020, 0, 0, 0, 0, 1, 16'hCAFE);
        cycle();
        check("tie_i_done", 32'(bus.i_done), 32'd1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        apply_stimulus(0, 0, 1, 1, 16'h0300, 16'h1234, 0, 0);
        cycle();
        apply_stimulus(0, 0, 1, 1, 16'h0999, 16'h5555, 0, 0);
        for (int k = 0; k < 3; k++) begin
            check("wr_addr_stable",  32'(bus.mem_addr), 32'h0300);
            check("wr_wdata_stable", 32'(bus.mem_wdata), 32'h1234);
            check("wr_we",           32'(bus.mem_we), 32'd1);
            cycle();
        end
        check("wr_addr_stable", 32'(bus.mem_addr), 32'h0300);
        apply_stimulus(0, 0, 1, 1, 16'h0999, 16'h5555, 1, 16'h7E7E);
        cycle();
        check("wr_done",   32'(bus.d_done), 32'd1);
        check("wr_rdata",  32'(bus.d_rdata), 32'hBEEF);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        apply_stimulus(1, 16'h0040, 0, 0, 0, 0, 0, 0);
        cycle();
        for (int k = 0; k < TOUT - 1; k++) begin
            cycle();
            check("to_waiting", 32'(bus.i_done), 32'd0);
        end
        cycle();
        check("to_done", 32'(bus.i_done), 32'd1);
        check("to_err",  32'(bus.timeout_err), 32'd1);
        check("to_rdata_kept", 32'(bus.i_rdata), 32'hCAFE);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("to_sticky", 32'(bus.timeout_err), 32'd1);

        apply_stimulus(0, 0, 1, 0, 16'h0600, 0, 0, 0);
        cycle();
        reset = 1'b1;
        cycle();
        check("rst_srv_req",  32'(bus.mem_req), 32'd0);
        check("rst_srv_busy", 32'(bus.busy), 32'd0);
        check("rst_srv_done", 32'(bus.d_done), 32'd0);
        check("rst_srv_err",  32'(bus.timeout_err), 32'd0);
        reset = 1'b0;
        cycle();
        check("rst_restart", 32'(bus.mem_addr), 32'h0600);
        apply_stimulus(0, 0, 1, 0, 16'h0600, 0, 1, 16'h7777);
        cycle();
        check("rst_restart_done", 32'(bus.d_done), 32'd1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        for (int t = 0; t <= SLIM + 1; t++) begin
            apply_stimulus(1, 16'h0050, 1, 0, 16'(16'h0400 + t), 0, 0, 0);
            cycle();
            if (t == SLIM) check("starve_fetch_wins", 32'(bus.mem_addr), 32'h0050);
            else           check("starve_data_wins",  32'(bus.mem_addr), 32'(16'h0400 + t));
            apply_stimulus(0, 16'h0050, 1, 0, 16'(16'h0400 + t), 0, 1, 16'(16'h1000 + t));
            cycle();
            apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
            cycle();
        end

        for (int n = 0; n < 3000; n++) begin
            logic ir;
            logic dr;
            ir = (bus.i_req && !m_idone) ? 1'b1 : 1'($urandom_range(0, 1));
            dr = (bus.d_req && !m_ddone) ? 1'b1 : 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 63) == 0);
            apply_stimulus(ir, 16'($urandom), dr, 1'($urandom_range(0, 1)),
                           16'($urandom), 16'($urandom),
                           ($urandom_range(0, 3) == 0), 16'($urandom));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
